// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges ALU and load results onto the register-file write port
module writeback_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_W-1:0]            alu_reg,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic                         mem_valid,
    input  logic [ADDR_W-1:0]            mem_reg,
    input  logic [DATA_W-1:0]            mem_data,
    output logic                         wb_en,
    output logic [ADDR_W-1:0]            wb_reg,
    output logic [DATA_W-1:0]            wb_data,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] ent_reg_q  [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DEPTH-1:0]  ent_live_q, ent_live_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic alu_accept;
    logic fifo_nonempty;
    logic push;
    logic pop;

    assign alu_ready     = (count_q < CW'(DEPTH));
    assign alu_accept    = alu_valid & alu_ready;
    assign fifo_nonempty = (count_q != '0);
    assign pop           = ~mem_valid & fifo_nonempty;
    // Bypass only when nothing older is queued, so ALU program order holds.
    assign push          = alu_accept & (mem_valid | fifo_nonempty);

    always_comb begin
        wb_en_d    = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;
        ent_live_d = ent_live_q;
        count_d    = count_q + CW'(push) - CW'(pop);

        if (mem_valid) begin
            wb_en_d   = 1'b1;
            wb_reg_d  = mem_reg;
            wb_data_d = mem_data;
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_live_q[i] && ent_reg_q[i] == mem_reg) begin
                    ent_live_d[i] = 1'b0;
                end
            end
        end else if (fifo_nonempty) begin
            ent_live_d[rd_ptr_q] = 1'b0;
            if (ent_live_q[rd_ptr_q]) begin
                wb_en_d   = 1'b1;
                wb_reg_d  = ent_reg_q[rd_ptr_q];
                wb_data_d = ent_data_q[rd_ptr_q];
            end
        end else if (alu_accept) begin
            wb_en_d   = 1'b1;
            wb_reg_d  = alu_reg;
            wb_data_d = alu_data;
        end

        // The same-cycle push is younger than the load, so it stays live.
        if (push) begin
            ent_live_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q    <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ent_live_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            wb_en_q    <= wb_en_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
            count_q    <= count_d;
            ent_live_q <= ent_live_d;
            if (push) begin
                ent_reg_q[wr_ptr_q]  <= alu_reg;
                ent_data_q[wr_ptr_q] <= alu_data;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    assign wb_en      = wb_en_q;
    assign wb_reg     = wb_reg_q;
    assign wb_data    = wb_data_q;
    assign fifo_count = count_q;
    assign busy       = fifo_nonempty;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [2:0]  fifo_count;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_reg    (mem_reg),
        .mem_data   (mem_data),
        .wb_en      (wb_en),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        alu_valid = av;
        alu_reg   = ar;
        alu_data  = ad;
        mem_valid = mv;
        mem_reg   = mr;
        mem_data  = md;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic en, input logic [4:0] r,
                            input logic [31:0] d, input logic [2:0] cnt);
        check({tag, ".en"}, 64'(wb_en), 64'(en));
        if (en) begin
            check({tag, ".reg"}, 64'(wb_reg), 64'(r));
            check({tag, ".data"}, 64'(wb_data), 64'(d));
        end
        check({tag, ".count"}, 64'(fifo_count), 64'(cnt));
        check({tag, ".busy"}, 64'(busy), 64'(cnt != 3'd0));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #12;
        check("reset.en", 64'(wb_en), 64'd0);
        check("reset.reg", 64'(wb_reg), 64'd0);
        check("reset.data", 64'(wb_data), 64'd0);
        check("reset.count", 64'(fifo_count), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.ready", 64'(alu_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Bypass: three back-to-back ALU writes with an empty FIFO
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd3, 32'hAAAA0001, 1'b0, 5'd0, 32'h0);
            tick();
            check_wb("bypass", 1'b1, 5'd3, 32'hAAAA0001, 3'd0);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        check_wb("bypass.idle", 1'b0, 5'd0, 32'h0, 3'd0);
        check("bypass.idle.hold_reg", 64'(wb_reg), 64'd3);
        check("bypass.idle.hold_data", 64'(wb_data), 64'hAAAA0001);

        // Conflict then drain
        drive(1'b1, 5'd8, 32'h1, 1'b1, 5'd7, 32'hDEAD);
        tick();
        check_wb("conflict.mem", 1'b1, 5'd7, 32'hDEAD, 3'd1);
        drive(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'h0);
        tick();
        check_wb("conflict.pop8", 1'b1, 5'd8, 32'h1, 3'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        check_wb("conflict.pop9", 1'b1, 5'd9, 32'h2, 3'd0);
        tick();
        check_wb("conflict.idle", 1'b0, 5'd0, 32'h0, 3'd0);

        // Full: six loads with the ALU offering every cycle, holding when stalled
        for (int k = 0; k < 6; k++) begin
            check($sformatf("full.ready%0d", k), 64'(alu_ready), 64'(k < 4));
            drive(1'b1, (k < 4) ? 5'(k + 1) : 5'd5, 32'h10 + 32'(k),
                  1'b1, 5'd20, 32'h100 + 32'(k));
            tick();
            check_wb($sformatf("full.mem%0d", k), 1'b1, 5'd20, 32'h100 + 32'(k),
                     (k < 4) ? 3'(k + 1) : 3'd4);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_wb($sformatf("full.drain%0d", k), 1'b1, 5'(k + 1), 32'h10 + 32'(k), 3'(3 - k));
        end

        // Squash: buffered r10 killed by a later load to r10
        drive(1'b1, 5'd10, 32'h5, 1'b1, 5'd20, 32'h1);
        tick();
        check_wb("squash.ld20", 1'b1, 5'd20, 32'h1, 3'd1);
        drive(1'b1, 5'd11, 32'h6, 1'b1, 5'd21, 32'h2);
        tick();
        check_wb("squash.ld21", 1'b1, 5'd21, 32'h2, 3'd2);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h99);
        tick();
        check_wb("squash.ld10", 1'b1, 5'd10, 32'h99, 3'd2);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        check_wb("squash.dead", 1'b0, 5'd0, 32'h0, 3'd1);
        check("squash.dead.hold_data", 64'(wb_data), 64'h99);
        tick();
        check_wb("squash.r11", 1'b1, 5'd11, 32'h6, 3'd0);

        // Same-cycle younger ALU result to the load's register stays live
        drive(1'b1, 5'd12, 32'h8, 1'b1, 5'd12, 32'h7);
        tick();
        check_wb("younger.mem", 1'b1, 5'd12, 32'h7, 3'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        check_wb("younger.alu", 1'b1, 5'd12, 32'h8, 3'd0);

        // Reset mid-traffic with three entries buffered
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'(k + 1), 32'h40 + 32'(k), 1'b1, 5'd20, 32'h200);
            tick();
        end
        check_wb("midrst.pre", 1'b1, 5'd20, 32'h200, 3'd3);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        #1;
        check_wb("midrst.async", 1'b0, 5'd0, 32'h0, 3'd0);
        check("midrst.ready", 64'(alu_ready), 64'd1);
        check("midrst.reg", 64'(wb_reg), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
        tick();
        check_wb("midrst.after", 1'b1, 5'd5, 32'h11, 3'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        check_wb("midrst.idle", 1'b0, 5'd0, 32'h0, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage directly upstream of the 32x32 register file.
- Merges two result sources onto the single register-file write port (write enable, write address, write data):
  - the single-cycle ALU;
  - the variable-latency load unit.
- ALU results that cannot be written immediately wait in a small in-order FIFO.
- Load results always win the port. A load result squashes any buffered, older ALU result to the same register.

Parameters:
DATA_W, 32, width of result data
ADDR_W, 5, register index width
DEPTH, 4, ALU buffer entries (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
alu_valid  input  1  ALU result present this cycle
alu_ready  output  1  arbiter can accept ALU result this cycle
alu_reg  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load result present; always accepted, no ready
mem_reg  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
wb_en  output  1  register-file write enable, registered
wb_reg  output  ADDR_W  register-file write address, registered
wb_data  output  DATA_W  register-file write data, registered
fifo_count  output  clog2(DEPTH+1)  live+dead entries held
busy  output  1  fifo_count != 0

Behaviour:
- Reset (async, immediate):
  - wb_en=0, wb_reg=0, wb_data=0, fifo_count=0, busy=0.
  - All FIFO entries cleared; pointers=0.
  - A result in flight during reset is lost.
- alu_ready = (fifo_count < DEPTH), combinational from registered count only. It does not depend on mem_valid or on a same-cycle pop.
- ALU accept = alu_valid & alu_ready. alu_valid with alu_ready=0 is ignored. The upstream must hold the result.
- Port selection each cycle (priority order), using pre-edge state:
  1. mem_valid: write mem_reg/mem_data. No FIFO pop.
  2. else FIFO non-empty: pop head.
     - Head live: write its reg/data.
     - Head dead: wb_en=0 for that cycle.
  3. else ALU accept: write alu_reg/alu_data directly (bypass, no FIFO).
  4. else wb_en=0; wb_reg/wb_data hold previous values.
- Push: an accepted ALU result is pushed to the FIFO tail whenever case 1 or case 2 applies. This preserves ALU program order; the bypass is used only when the FIFO is empty and mem_valid=0.
- Simultaneous push and pop leaves fifo_count unchanged. Pointers wrap modulo DEPTH.
- Latency:
  - Accepted input to wb_en: exactly 1 cycle when granted.
  - A buffered entry is written 1 cycle after the edge on which it is popped.
- Squash rule: when mem_valid, every live FIFO entry with reg == mem_reg is marked dead at that edge.
  - The ALU result pushed in the same cycle is younger and stays live even if its reg matches.
  - Dead entries still occupy slots until popped.
- Back-to-back loads starve the FIFO indefinitely. There is no fairness counter; this is required behaviour.
- fifo_count is never >DEPTH and never <0. Pops occur only when count>0.

Test Plan:
- Reset mid-traffic: assert rst with 3 entries buffered and wb_en=1 -> same cycle wb_en=0, fifo_count=0, alu_ready=1. After release, ALU r5=0x11 -> next cycle wb_en=1, wb_reg=5, wb_data=0x11.
- Bypass: FIFO empty, ALU r3=0xAAAA0001 for 3 consecutive cycles -> three consecutive wb writes to r3, 1-cycle latency, fifo_count stays 0.
- Conflict then drain:
  - Same cycle: mem r7=0xDEAD and ALU r8=0x1 -> wb r7=0xDEAD, fifo_count=1.
  - Next cycle: ALU r9=0x2 -> wb r8=0x1, count stays 1.
  - Idle -> wb r9=0x2, count=0.
- Full: hold mem_valid for 6 cycles with ALU offering every cycle -> 4 accepted (regs 1..4), alu_ready=0 from count=4. After mem stops, writes r1,r2,r3,r4 in order on 4 consecutive cycles.
- Squash:
  - Buffer ALU r10=0x5 and r11=0x6 behind a load.
  - Then mem r10=0x99 -> wb r10=0x99.
  - Drain: one cycle wb_en=0 (dead r10), then wb r11=0x6. r10 is never overwritten with 0x5.
- Same-cycle younger ALU: mem r12=0x7 and ALU r12=0x8 together with FIFO empty -> wb r12=0x7, then wb r12=0x8 (entry kept live).
